// File: rtl/ps2_key_controller.sv
// PS/2 key event controller: brings the reader's byte strobe into the clk domain, decodes the
// E0/F0/E1 prefix grammar into key events, flags error bytes and stalled sequences, and queues
// events in a small first-word fall-through FIFO with a valid/ready handshake.
//
// state  | meaning
// IDLE   | waiting for the first byte of a sequence
// EXT    | E0 seen, waiting for code or F0
// BRK    | F0 seen, waiting for released key code
// EXTBRK | E0 F0 seen, waiting for released extended key code
// SKIP   | inside the 8-byte pause sequence, counting bytes
module ps2_key_controller #(
    parameter int FIFO_DEPTH      = 4,
    parameter int TIMEOUT_CYCLES  = 100000,
    parameter int DROP_FAKE_SHIFT = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       end_scan,
    input  logic [7:0] scan_code,
    output logic       ev_valid,
    input  logic       ev_ready,
    output logic [7:0] ev_code,
    output logic       ev_break,
    output logic       ev_ext,
    output logic       overflow,
    output logic       kbd_err,
    input  logic       clear_flags
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {IDLE, EXT, BRK, EXTBRK, SKIP} state_t;

    state_t            state, state_nxt;
    logic              s1, s2, s3;
    logic              byte_stb;
    logic [7:0]        byte_reg;
    logic [2:0]        skip_cnt, skip_nxt;
    logic [TO_W-1:0]   to_cnt, to_nxt;
    logic              err_set;
    logic              push, push_ok, pop, full, fake;
    logic              push_brk, push_ext;
    logic [7:0]        push_code;
    logic [9:0]        mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [CNT_W-1:0]  count;
    logic              is_err_byte;

    // end_scan synchroniser and rising-edge strobe; flops reset high so a level already
    // high when reset releases does not look like a new frame
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1       <= 1'b1;
            s2       <= 1'b1;
            s3       <= 1'b1;
            byte_stb <= 1'b0;
            byte_reg <= 8'h00;
        end else begin
            s1       <= end_scan;
            s2       <= s1;
            s3       <= s2;
            byte_stb <= s2 & ~s3;
            if (s2 & ~s3)
                byte_reg <= scan_code;
        end
    end

    assign is_err_byte = (byte_reg == 8'h00) || (byte_reg == 8'hFF) ||
                         (byte_reg == 8'hFC) || (byte_reg == 8'hFD);
    // fake shifts are extended events around some keys that the host does not want
    assign fake = (DROP_FAKE_SHIFT != 0) && ((byte_reg == 8'h12) || (byte_reg == 8'h59));

    // decoder state, pause byte counter and stall timer registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            skip_cnt <= 3'd0;
            to_cnt   <= '0;
        end else begin
            state    <= state_nxt;
            skip_cnt <= skip_nxt;
            to_cnt   <= to_nxt;
        end
    end

    // prefix decoding, event generation and prefix timeout; a byte beats a same-cycle timeout
    always_comb begin
        state_nxt = state;
        skip_nxt  = skip_cnt;
        to_nxt    = to_cnt;
        err_set   = 1'b0;
        push      = 1'b0;
        push_code = byte_reg;
        push_brk  = 1'b0;
        push_ext  = 1'b0;
        if (byte_stb) begin
            to_nxt = '0;
            case (state)
                IDLE: begin
                    if (byte_reg == 8'hE0)
                        state_nxt = EXT;
                    else if (byte_reg == 8'hF0)
                        state_nxt = BRK;
                    else if (byte_reg == 8'hE1) begin
                        state_nxt = SKIP;
                        skip_nxt  = 3'd7;
                    end else if ((byte_reg == 8'hAA) || (byte_reg == 8'hFA) || (byte_reg == 8'hEE))
                        state_nxt = IDLE;
                    else if (is_err_byte)
                        err_set = 1'b1;
                    else
                        push = 1'b1;
                end
                EXT: begin
                    if (is_err_byte) begin
                        err_set   = 1'b1;
                        state_nxt = IDLE;
                    end else if (byte_reg == 8'hF0)
                        state_nxt = EXTBRK;
                    else if (byte_reg == 8'hE0)
                        state_nxt = EXT;
                    else begin
                        push      = ~fake;
                        push_ext  = 1'b1;
                        state_nxt = IDLE;
                    end
                end
                BRK: begin
                    state_nxt = IDLE;
                    if (is_err_byte)
                        err_set = 1'b1;
                    else begin
                        push     = 1'b1;
                        push_brk = 1'b1;
                    end
                end
                EXTBRK: begin
                    state_nxt = IDLE;
                    if (is_err_byte)
                        err_set = 1'b1;
                    else begin
                        push     = ~fake;
                        push_brk = 1'b1;
                        push_ext = 1'b1;
                    end
                end
                SKIP: begin
                    skip_nxt = skip_cnt - 3'd1;
                    if (skip_cnt == 3'd1) begin
                        push      = 1'b1;
                        push_ext  = 1'b1;
                        push_code = 8'hE1;
                        state_nxt = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end else if (state == IDLE) begin
            to_nxt = '0;
        end else if (to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
            to_nxt    = '0;
            state_nxt = IDLE;
            skip_nxt  = 3'd0;
            err_set   = 1'b1;
        end else begin
            to_nxt = to_cnt + TO_W'(1);
        end
    end

    assign full    = (count == CNT_W'(FIFO_DEPTH));
    assign pop     = ev_valid & ev_ready;
    assign push_ok = push & (~full | pop);

    // FIFO pointers and occupancy; a push into a full queue survives only with a pop
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            if (push_ok && !pop)
                count <= count + CNT_W'(1);
            else if (!push_ok && pop)
                count <= count - CNT_W'(1);
        end
    end

    // FIFO storage; when full with a pop the write lands on the slot being read out
    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_ptr] <= {push_ext, push_brk, push_code};
    end

    // sticky flags; clear_flags beats a set in the same cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow <= 1'b0;
            kbd_err  <= 1'b0;
        end else if (clear_flags) begin
            overflow <= 1'b0;
            kbd_err  <= 1'b0;
        end else begin
            if (push && full && !pop)
                overflow <= 1'b1;
            if (err_set)
                kbd_err <= 1'b1;
        end
    end

    assign ev_valid = (count != '0);
    assign {ev_ext, ev_break, ev_code} = ev_valid ? mem[rd_ptr] : 10'h000;

endmodule

// File: tb/tb_ps2_key_controller.sv
// Directed bench for ps2_key_controller: latency, prefix grammar, pause sequence, overflow,
// timeout, status/error filtering and reset in the middle of a sequence.
module tb_ps2_key_controller;

    localparam int TO = 40;

    logic       clk = 1'b0;
    logic       reset;
    logic       end_scan;
    logic [7:0] scan_code;
    logic       ev_valid;
    logic       ev_ready;
    logic [7:0] ev_code;
    logic       ev_break;
    logic       ev_ext;
    logic       overflow;
    logic       kbd_err;
    logic       clear_flags;

    int vectors = 0;
    int miscompares = 0;
    logic [9:0] got_q[$];

    ps2_key_controller #(.FIFO_DEPTH(4), .TIMEOUT_CYCLES(TO), .DROP_FAKE_SHIFT(1)) dut (
        .clk(clk), .reset(reset), .end_scan(end_scan), .scan_code(scan_code),
        .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_code(ev_code), .ev_break(ev_break),
        .ev_ext(ev_ext), .overflow(overflow), .kbd_err(kbd_err), .clear_flags(clear_flags)
    );

    always #5 clk = ~clk;

    // records every accepted event as {ext, brk, code}
    always @(negedge clk) begin
        #1;
        if (!reset && ev_valid && ev_ready)
            got_q.push_back({ev_ext, ev_break, ev_code});
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        scan_code = b;
        end_scan  = 1'b1;
        repeat (6) @(negedge clk);
        end_scan = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic test_reset;
        reset = 1'b1; end_scan = 1'b0; scan_code = 8'h00; ev_ready = 1'b1; clear_flags = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if ({ev_valid, ev_code, ev_break, ev_ext, overflow, kbd_err} !== 13'h0) begin
            miscompares++;
            $display("FAIL reset_outputs: got %h expected 0",
                     {ev_valid, ev_code, ev_break, ev_ext, overflow, kbd_err});
        end
        reset = 1'b0;
        repeat (5) @(negedge clk);
        vectors++;
        if (ev_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_release_valid: got %b expected 0", ev_valid);
        end
        got_q.delete();
    endtask

    task automatic test_latency;
        logic exp_v;
        ev_ready = 1'b1;
        @(negedge clk);
        scan_code = 8'h1C;
        end_scan  = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            exp_v = (k == 4);
            vectors++;
            if (ev_valid !== exp_v) begin
                miscompares++;
                $display("FAIL latency_valid_edge%0d: got %b expected %b", k, ev_valid, exp_v);
            end
            if (k == 4) begin
                vectors++;
                if ({ev_ext, ev_break, ev_code} !== {2'b00, 8'h1C}) begin
                    miscompares++;
                    $display("FAIL latency_event: got %h expected %h",
                             {ev_ext, ev_break, ev_code}, {2'b00, 8'h1C});
                end
            end
        end
        end_scan = 1'b0;
        repeat (6) @(negedge clk);
        got_q.delete();
    endtask

    task automatic test_prefixes;
        got_q.delete();
        send_byte(8'hF0); send_byte(8'h1C);
        send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
        vectors++;
        if (got_q.size() !== 2) begin
            miscompares++;
            $display("FAIL prefix_count: got %0d expected 2", got_q.size());
        end else begin
            vectors++;
            if (got_q[0] !== {2'b01, 8'h1C}) begin
                miscompares++;
                $display("FAIL prefix_break: got %h expected %h", got_q[0], {2'b01, 8'h1C});
            end
            vectors++;
            if (got_q[1] !== {2'b11, 8'h75}) begin
                miscompares++;
                $display("FAIL prefix_ext_break: got %h expected %h", got_q[1], {2'b11, 8'h75});
            end
        end
        got_q.delete();
    endtask

    task automatic test_pause;
        logic [7:0] seq [8] = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
        got_q.delete();
        for (int i = 0; i < 7; i++) send_byte(seq[i]);
        vectors++;
        if (got_q.size() !== 0) begin
            miscompares++;
            $display("FAIL pause_early: got %0d events expected 0", got_q.size());
        end
        send_byte(seq[7]);
        vectors++;
        if (got_q.size() !== 1) begin
            miscompares++;
            $display("FAIL pause_count: got %0d expected 1", got_q.size());
        end else begin
            vectors++;
            if (got_q[0] !== {2'b10, 8'hE1}) begin
                miscompares++;
                $display("FAIL pause_event: got %h expected %h", got_q[0], {2'b10, 8'hE1});
            end
        end
        got_q.delete();
    endtask

    task automatic test_overflow;
        logic [9:0] exp_q [5] = '{10'h001, 10'h002, 10'h003, 10'h004, 10'h006};
        ev_ready = 1'b0;
        got_q.delete();
        for (int i = 1; i <= 5; i++) send_byte(8'(i));
        vectors++;
        if ({overflow, ev_valid, ev_code} !== {2'b11, 8'h01}) begin
            miscompares++;
            $display("FAIL ovf_full_state: got ovf=%b v=%b code=%h expected 1 1 01",
                     overflow, ev_valid, ev_code);
        end
        @(negedge clk);
        scan_code = 8'h06;
        end_scan  = 1'b1;
        repeat (3) @(negedge clk);
        ev_ready = 1'b1;
        @(negedge clk);
        ev_ready = 1'b0;
        vectors++;
        if ({ev_valid, ev_code} !== {1'b1, 8'h02}) begin
            miscompares++;
            $display("FAIL ovf_push_pop_head: got v=%b code=%h expected 1 02", ev_valid, ev_code);
        end
        end_scan = 1'b0;
        repeat (4) @(negedge clk);
        ev_ready = 1'b1;
        repeat (8) @(negedge clk);
        vectors++;
        if (got_q.size() !== 5) begin
            miscompares++;
            $display("FAIL ovf_drain_count: got %0d expected 5", got_q.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                vectors++;
                if (got_q[i] !== exp_q[i]) begin
                    miscompares++;
                    $display("FAIL ovf_drain_%0d: got %h expected %h", i, got_q[i], exp_q[i]);
                end
            end
        end
        clear_flags = 1'b1;
        @(negedge clk);
        clear_flags = 1'b0;
        vectors++;
        if (overflow !== 1'b0) begin
            miscompares++;
            $display("FAIL ovf_clear: got %b expected 0", overflow);
        end
        got_q.delete();
    endtask

    task automatic test_timeout;
        got_q.delete();
        send_byte(8'hE0);
        vectors++;
        if (kbd_err !== 1'b0) begin
            miscompares++;
            $display("FAIL timeout_early: got %b expected 0", kbd_err);
        end
        repeat (TO) @(negedge clk);
        vectors++;
        if ({kbd_err, 5'(got_q.size())} !== {1'b1, 5'd0}) begin
            miscompares++;
            $display("FAIL timeout_flag: got err=%b events=%0d expected 1 0", kbd_err, got_q.size());
        end
        send_byte(8'h1C);
        vectors++;
        if (got_q.size() !== 1 || got_q[0] !== {2'b00, 8'h1C}) begin
            miscompares++;
            $display("FAIL timeout_next_make: got n=%0d first=%h expected 1 01c",
                     got_q.size(), (got_q.size() > 0) ? got_q[0] : 10'h3FF);
        end
        clear_flags = 1'b1;
        @(negedge clk);
        clear_flags = 1'b0;
        vectors++;
        if (kbd_err !== 1'b0) begin
            miscompares++;
            $display("FAIL timeout_clear: got %b expected 0", kbd_err);
        end
        got_q.delete();
        send_byte(8'hE0); send_byte(8'h12);
        send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h59);
        vectors++;
        if (got_q.size() !== 0) begin
            miscompares++;
            $display("FAIL fake_shift_drop: got %0d events expected 0", got_q.size());
        end
        got_q.delete();
    endtask

    task automatic test_filters;
        got_q.delete();
        send_byte(8'hAA); send_byte(8'hFA); send_byte(8'hEE);
        vectors++;
        if ({kbd_err, 5'(got_q.size())} !== 6'd0) begin
            miscompares++;
            $display("FAIL status_drop: got err=%b events=%0d expected 0 0", kbd_err, got_q.size());
        end
        send_byte(8'hFF);
        vectors++;
        if ({kbd_err, 5'(got_q.size())} !== {1'b1, 5'd0}) begin
            miscompares++;
            $display("FAIL err_byte: got err=%b events=%0d expected 1 0", kbd_err, got_q.size());
        end
        clear_flags = 1'b1;
        send_byte(8'hFC);
        clear_flags = 1'b0;
        @(negedge clk);
        vectors++;
        if (kbd_err !== 1'b0) begin
            miscompares++;
            $display("FAIL clear_wins: got %b expected 0", kbd_err);
        end
        send_byte(8'hE0); send_byte(8'h00); send_byte(8'h1C);
        vectors++;
        if (kbd_err !== 1'b1 || got_q.size() !== 1 || got_q[0] !== {2'b00, 8'h1C}) begin
            miscompares++;
            $display("FAIL ext_err_byte: got err=%b n=%0d first=%h expected 1 1 01c", kbd_err,
                     got_q.size(), (got_q.size() > 0) ? got_q[0] : 10'h3FF);
        end
        clear_flags = 1'b1;
        @(negedge clk);
        clear_flags = 1'b0;
        got_q.delete();
    endtask

    task automatic test_reset_midseq;
        ev_ready = 1'b0;
        got_q.delete();
        send_byte(8'h1C); send_byte(8'h2C); send_byte(8'hF0);
        @(negedge clk);
        scan_code = 8'h1C;
        end_scan  = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        vectors++;
        if ({ev_valid, ev_code, ev_break, ev_ext, overflow, kbd_err} !== 13'h0) begin
            miscompares++;
            $display("FAIL midseq_reset_outputs: got %h expected 0",
                     {ev_valid, ev_code, ev_break, ev_ext, overflow, kbd_err});
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (8) @(negedge clk);
        vectors++;
        if (ev_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL midseq_high_at_release: got %b expected 0", ev_valid);
        end
        ev_ready = 1'b1;
        end_scan = 1'b0;
        repeat (6) @(negedge clk);
        end_scan = 1'b1;
        repeat (6) @(negedge clk);
        end_scan = 1'b0;
        repeat (6) @(negedge clk);
        vectors++;
        if (got_q.size() !== 1 || got_q[0] !== {2'b00, 8'h1C}) begin
            miscompares++;
            $display("FAIL midseq_after_release: got n=%0d first=%h expected 1 01c",
                     got_q.size(), (got_q.size() > 0) ? got_q[0] : 10'h3FF);
        end
    endtask

    initial begin
        test_reset;
        test_latency;
        test_prefixes;
        test_pause;
        test_overflow;
        test_timeout;
        test_filters;
        test_reset_midseq;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
